// File: rtl/branch_resolve_unit_if.sv
// Bundle between the branch resolve unit and the fetch/execute pipeline.
// The optional statistics counters appear only when BRU_STATS_EN is defined.
//
// Handshake: ex_valid qualifies every ex_* field and the type bits for one
// clock edge. The unit is always ready, so there is no ready signal.
// redirect_valid is a one-cycle pulse that qualifies redirect_pc.
// jump_flag is also a one-cycle pulse, registered alongside it.
interface branch_resolve_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] if_pc;
    logic            if_pred_taken;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred_taken;
    logic            beq, bne, blt, bge, bltu, bgeu, jal, jalr;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            jump_flag;
`ifdef BRU_STATS_EN
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispredicts;
    logic [31:0]     stat_jumps;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_target, ex_pred_taken,
               beq, bne, blt, bge, bltu, bgeu, jal, jalr, rs1_val, rs2_val,
        input  if_pred_taken, redirect_valid, redirect_pc, jump_flag,
               stat_branches, stat_mispredicts, stat_jumps
    );
    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_target, ex_pred_taken,
               beq, bne, blt, bge, bltu, bgeu, jal, jalr, rs1_val, rs2_val,
        output if_pred_taken, redirect_valid, redirect_pc, jump_flag,
               stat_branches, stat_mispredicts, stat_jumps
    );
`else
    modport master (
        output if_pc, ex_valid, ex_pc, ex_target, ex_pred_taken,
               beq, bne, blt, bge, bltu, bgeu, jal, jalr, rs1_val, rs2_val,
        input  if_pred_taken, redirect_valid, redirect_pc, jump_flag
    );
    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_target, ex_pred_taken,
               beq, bne, blt, bge, bltu, bgeu, jal, jalr, rs1_val, rs2_val,
        output if_pred_taken, redirect_valid, redirect_pc, jump_flag
    );
`endif
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit. It evaluates the RV32I branch and jump conditions and
// predicts with a PC-indexed table of 2-bit counters. On a mispredict it
// issues a registered redirect.
// Optional macro BRU_STATS_EN adds three wrapping 32-bit event counters.
module branch_resolve_unit #(
    parameter int         XLEN      = 32,
    parameter int         BHT_DEPTH = 64,
    parameter int         BHT_IDX_W = $clog2(BHT_DEPTH),
    parameter logic [1:0] CNT_INIT  = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    branch_resolve_unit_if.slave bru
);
    logic [1:0]           bht [BHT_DEPTH];
    logic [7:0]           type_bits;
    logic                 multi_type;
    logic                 resolve;
    logic                 is_cond;
    logic                 is_jump;
    logic                 eq, lt, ltu;
    logic                 taken;
    logic                 mispredict;
    logic [XLEN-1:0]      target_fixed;
    logic [XLEN-1:0]      next_redirect_pc;
    logic [BHT_IDX_W-1:0] if_idx;
    logic [BHT_IDX_W-1:0] ex_idx;
    logic [1:0]           cnt_next;
    logic                 unused_pc_bits;

    assign type_bits  = {bru.jalr, bru.jal, bru.bgeu, bru.bltu,
                         bru.bge, bru.blt, bru.bne, bru.beq};
    assign multi_type = (type_bits & (type_bits - 8'd1)) != 8'd0;
    // Exactly one type bit set together with ex_valid is a resolvable instruction
    assign resolve    = bru.ex_valid && (type_bits != 8'd0) && !multi_type;
    assign is_cond    = |type_bits[5:0];
    assign is_jump    = bru.jal | bru.jalr;

    assign if_idx = bru.if_pc[BHT_IDX_W+1:2];
    assign ex_idx = bru.ex_pc[BHT_IDX_W+1:2];
    // Only the index bits of the fetch PC matter for the lookup
    assign unused_pc_bits = ^{bru.if_pc[XLEN-1:BHT_IDX_W+2], bru.if_pc[1:0]};

    // The table read has no bypass, so a same-cycle update is seen one cycle later
    assign bru.if_pred_taken = bht[if_idx][1];

    // Evaluate the branch conditions and pick the redirect address
    always_comb begin
        eq    = (bru.rs1_val == bru.rs2_val);
        lt    = ($signed(bru.rs1_val) < $signed(bru.rs2_val));
        ltu   = (bru.rs1_val < bru.rs2_val);
        taken = (bru.beq & eq) | (bru.bne & ~eq) | (bru.blt & lt) |
                (bru.bge & ~lt) | (bru.bltu & ltu) | (bru.bgeu & ~ltu) |
                bru.jal | bru.jalr;
        // The jalr target is never predicted, so every jalr redirects
        mispredict = bru.jalr | (bru.jal & ~bru.ex_pred_taken) |
                     (is_cond & (taken != bru.ex_pred_taken));
        target_fixed = bru.ex_target;
        if (bru.jalr) begin
            target_fixed[0] = 1'b0;
        end
        next_redirect_pc = taken ? target_fixed : (bru.ex_pc + XLEN'(4));
    end

    // Saturating counter step for the entry being resolved
    always_comb begin
        cnt_next = bht[ex_idx];
        if (taken) begin
            if (bht[ex_idx] != 2'b11) cnt_next = bht[ex_idx] + 2'b01;
        end else begin
            if (bht[ex_idx] != 2'b00) cnt_next = bht[ex_idx] - 2'b01;
        end
    end

    // Register the redirect and the outcome; both last one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bru.redirect_valid <= 1'b0;
            bru.redirect_pc    <= '0;
            bru.jump_flag      <= 1'b0;
        end else begin
            bru.redirect_valid <= resolve & mispredict;
            bru.jump_flag      <= resolve & taken;
            if (resolve) begin
                bru.redirect_pc <= next_redirect_pc;
            end
        end
    end

    // Train the history table on conditional branches only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= CNT_INIT;
            end
        end else if (resolve && is_cond) begin
            bht[ex_idx] <= cnt_next;
        end
    end

`ifdef BRU_STATS_EN
    // Event counters, updated on the resolving edge and wrapping naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bru.stat_branches    <= '0;
            bru.stat_mispredicts <= '0;
            bru.stat_jumps       <= '0;
        end else if (resolve) begin
            if (is_cond)    bru.stat_branches    <= bru.stat_branches + 32'd1;
            if (mispredict) bru.stat_mispredicts <= bru.stat_mispredicts + 32'd1;
            if (is_jump)    bru.stat_jumps       <= bru.stat_jumps + 32'd1;
        end
    end
`endif

    // Decoders must never present more than one type bit at once
    assert property (@(posedge clk) disable iff (rst) !(bru.ex_valid && multi_type));

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised successor to the combinational branch-condition judge.
- Evaluates all RV32I branch and jump conditions internally from raw operands.
- Holds a PC-indexed branch history table (BHT) of 2-bit saturating counters that gives taken/not-taken predictions to fetch.
- Resolves branches in execute against the prediction and issues a registered redirect to the PC logic on mispredict.

Parameters:
- XLEN, 32, operand and PC width.
- BHT_DEPTH, 64, number of BHT entries; power of two, minimum 2.
- BHT_IDX_W, $clog2(BHT_DEPTH), index width (derived; do not override).
- CNT_INIT, 2'b01, counter value loaded at reset (weakly not-taken).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_pc  in  XLEN  fetch-stage PC used for prediction lookup.
- if_pred_taken  out  1  prediction for if_pc; combinational read of BHT.
- ex_valid  in  1  execute stage holds a valid control-transfer instruction this cycle.
- ex_pc  in  XLEN  PC of the execute-stage instruction.
- ex_target  in  XLEN  computed target (pc+imm, or rs1+imm for jalr).
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction.
- beq, bne, blt, bge, bltu, bgeu, jal, jalr  in  1 each  one-hot decoded type; all zero means not a control transfer.
- rs1_val, rs2_val  in  XLEN  compare operands.
- redirect_valid  out  1  registered; PC logic must load redirect_pc.
- redirect_pc  out  XLEN  registered redirect address.
- jump_flag  out  1  registered actual-taken outcome of the last resolved instruction.

Behaviour:
- Conditions:
  - eq = (rs1_val == rs2_val).
  - lt = signed compare; ltu = unsigned compare.
  - taken = beq&eq | bne&~eq | blt&lt | bge&~lt | bltu&ltu | bgeu&~ltu | jal | jalr.
- Prediction:
  - idx = pc[BHT_IDX_W+1:2].
  - if_pred_taken = BHT[idx(if_pc)][1]; combinational, zero latency.
- Resolution happens at the clock edge when ex_valid=1 and exactly one type bit is set.
  - Conditional branch: mispredict = (taken != ex_pred_taken).
  - jal: mispredict = ~ex_pred_taken.
  - jalr: always mispredict, since the target is not predicted.
  - redirect_pc = taken ? ex_target : ex_pc+4, modulo 2^XLEN. For jalr, bit 0 of the target is cleared.
  - redirect_valid = mispredict, and jump_flag = taken, both 1 cycle after the resolve edge.
  - Outputs hold for exactly one cycle; the next cycle returns redirect_valid to 0 unless a new resolve occurs.
- ex_valid=1 with no type bit set: no BHT update, redirect_valid=0, jump_flag=0.
- BHT update, conditional branches only, at the same edge:
  - taken: counter saturates up (11 stays 11).
  - not taken: counter saturates down (00 stays 00).
  - jal/jalr never update.
- Read/write collision: same-cycle if_pc lookup of an index being updated returns the OLD counter. No bypass.
- Reset (async, any time):
  - redirect_valid=0, redirect_pc=0, jump_flag=0.
  - All counters = CNT_INIT.
  - A pending redirect is dropped. First valid resolve is accepted at the first edge after rst deasserts.
- Multiple type bits set is illegal: no update and no redirect. Assertion fires in simulation.

Optional Feature:
- Macro BRU_STATS_EN.
- When defined, adds three 32-bit outputs, all reset to 0, each wrapping at 2^32:
  - stat_branches: count of resolved conditional branches.
  - stat_mispredicts: count of redirect_valid pulses.
  - stat_jumps: count of jal/jalr.
- Counters update on the same edge as resolution.
- When undefined, these ports and registers are absent; all other behaviour is identical.

Test Plan:
- After reset, if_pc=0x100 → if_pred_taken=0. beq, rs1=rs2=5, pred=0, target=0x200 → next cycle redirect_valid=1, redirect_pc=0x200, jump_flag=1.
- Same beq taken three more times at pc 0x100 → counter saturates 11. Then bne with equal operands, pred=1 → redirect_pc=0x104, and the counter becomes 10 (if_pred_taken still 1).
- blt rs1=0xFFFFFFFF, rs2=1 → taken. bltu with the same operands → not taken. Confirm redirects match the prediction bits supplied.
- jalr target=0x2001 → redirect_pc=0x2000, redirect_valid=1 regardless of pred. jal with pred=1 → no redirect, jump_flag=1, BHT unchanged.
- Update index 5 while if_pc maps to index 5 in the same cycle → old value is read; the new value is visible next cycle.
- Assert rst mid-resolve → outputs 0 immediately with no redirect pulse, and BHT entries return to 01. With BRU_STATS_EN, all stats read 0.
